// File: rtl/mem_req_arb_pkg.sv
// Shared types and constants for the two-port memory request arbiter.
package mem_req_arb_pkg;

   localparam logic [1:0] DATA_WIDTH_0  = 2'd0;
   localparam logic [1:0] DATA_WIDTH_8  = 2'd1;
   localparam logic [1:0] DATA_WIDTH_16 = 2'd2;
   localparam logic [1:0] DATA_WIDTH_32 = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD
   } arb_state_t;

   typedef enum logic {
      PORT_A,
      PORT_B
   } arb_port_t;

endpackage

// File: rtl/mem_req_arb_rr.sv
// Two-way round-robin picker: with both ports requesting, the one not served last wins.
module mem_req_arb_rr
   import mem_req_arb_pkg::*;
(
   input  logic [1:0] req,
   input  arb_port_t  last,
   output logic [1:0] gnt
);

   // NOTE: gnt gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last == PORT_A) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_req_arb.sv
// Merges the cartridge-bus port (A) and loader port (B) onto one memory request
// channel, one outstanding transaction at a time, holding addr/width until read data returns.
module mem_req_arb
   import mem_req_arb_pkg::*;
#(
   parameter int          ADDR_W  = 27,
   parameter int          TIMEOUT = 4096,
   parameter logic [31:0] TO_DATA = 32'hDEAD_BEEF
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              a_rd,
   input  logic              a_wr,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [1:0]        a_width,
   input  logic [31:0]       a_wr_data,
   output logic              a_ack,
   output logic [31:0]       a_rd_data,
   output logic              a_rd_valid,

   input  logic              b_rd,
   input  logic              b_wr,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [1:0]        b_width,
   input  logic [31:0]       b_wr_data,
   output logic              b_ack,
   output logic [31:0]       b_rd_data,
   output logic              b_rd_valid,

   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_data_width,
   output logic [31:0]       mem_wr_data,
   input  logic              mem_rd_ready,
   input  logic              mem_wr_ready,
   input  logic [31:0]       mem_rd_data,
   input  logic              mem_rd_valid,

   output logic              busy,
   output logic              timeout
);

   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t        state_q;
   arb_port_t         port_q;
   arb_port_t         last_q;
   logic              mem_rd_q;
   logic              mem_wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        width_q;
   logic [31:0]       wr_data_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       a_rd_data_q;
   logic [31:0]       b_rd_data_q;
   logic              a_rd_valid_q;
   logic              b_rd_valid_q;
   logic              timeout_q;

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              sel_b;
   logic              sel_rd;
   logic              hs;
   logic [31:0]       rd_result;

   assign req = {b_rd | b_wr, a_rd | a_wr};

   mem_req_arb_rr u_rr (
      .req  (req),
      .last (last_q),
      .gnt  (gnt)
   );

   // A port asserting both rd and wr is treated as a read.
   assign sel_b     = gnt[1];
   assign sel_rd    = sel_b ? b_rd : a_rd;
   assign hs        = (mem_rd_q & mem_rd_ready) | (mem_wr_q & mem_wr_ready);
   assign rd_result = mem_rd_valid ? mem_rd_data : TO_DATA;

   // NOTE: acks are combinational so the requester sees them in the handshake cycle itself.
   assign a_ack = hs & (port_q == PORT_A);
   assign b_ack = hs & (port_q == PORT_B);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         port_q       <= PORT_A;
         last_q       <= PORT_B;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         addr_q       <= '0;
         width_q      <= '0;
         wr_data_q    <= '0;
         cnt_q        <= '0;
         a_rd_data_q  <= '0;
         b_rd_data_q  <= '0;
         a_rd_valid_q <= 1'b0;
         b_rd_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         a_rd_valid_q <= 1'b0;
         b_rd_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|req) begin
                  port_q    <= sel_b ? PORT_B : PORT_A;
                  addr_q    <= sel_b ? b_addr : a_addr;
                  width_q   <= sel_b ? b_width : a_width;
                  wr_data_q <= sel_b ? b_wr_data : a_wr_data;
                  mem_rd_q  <= sel_rd;
                  mem_wr_q  <= ~sel_rd;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               if (hs) begin
                  mem_rd_q <= 1'b0;
                  mem_wr_q <= 1'b0;
                  last_q   <= port_q;
                  cnt_q    <= '0;
                  state_q  <= mem_rd_q ? WAIT_RD : IDLE;
               end
            end
            WAIT_RD: begin
               if (mem_rd_valid || (cnt_q == CNT_LAST)) begin
                  if (port_q == PORT_A) begin
                     a_rd_data_q  <= rd_result;
                     a_rd_valid_q <= 1'b1;
                  end else begin
                     b_rd_data_q  <= rd_result;
                     b_rd_valid_q <= 1'b1;
                  end
                  timeout_q <= ~mem_rd_valid;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_rd         = mem_rd_q;
   assign mem_wr         = mem_wr_q;
   assign mem_addr       = addr_q;
   assign mem_data_width = width_q;
   assign mem_wr_data    = wr_data_q;
   assign a_rd_data      = a_rd_data_q;
   assign b_rd_data      = b_rd_data_q;
   assign a_rd_valid     = a_rd_valid_q;
   assign b_rd_valid     = b_rd_valid_q;
   assign timeout        = timeout_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_req_arb.sv
// Scoreboard bench for mem_req_arb: expected grants and read returns are queued
// as stimulus is driven and checked when the arbiter produces them.
module tb_mem_req_arb;
   import mem_req_arb_pkg::*;

   localparam int ADDR_W  = 27;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              a_rd = 0, a_wr = 0, b_rd = 0, b_wr = 0;
   logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
   logic [1:0]        a_width = '0, b_width = '0;
   logic [31:0]       a_wr_data = '0, b_wr_data = '0;
   logic              a_ack, b_ack, a_rd_valid, b_rd_valid;
   logic [31:0]       a_rd_data, b_rd_data;
   logic              mem_rd, mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_data_width;
   logic [31:0]       mem_wr_data;
   logic              mem_rd_ready = 0, mem_wr_ready = 0, mem_rd_valid = 0;
   logic [31:0]       mem_rd_data = '0;
   logic              busy, timeout;

   always #5 clk = ~clk;

   mem_req_arb #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .rst(rst),
      .a_rd(a_rd), .a_wr(a_wr), .a_addr(a_addr), .a_width(a_width), .a_wr_data(a_wr_data),
      .a_ack(a_ack), .a_rd_data(a_rd_data), .a_rd_valid(a_rd_valid),
      .b_rd(b_rd), .b_wr(b_wr), .b_addr(b_addr), .b_width(b_width), .b_wr_data(b_wr_data),
      .b_ack(b_ack), .b_rd_data(b_rd_data), .b_rd_valid(b_rd_valid),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_width(mem_data_width),
      .mem_wr_data(mem_wr_data), .mem_rd_ready(mem_rd_ready), .mem_wr_ready(mem_wr_ready),
      .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
      .busy(busy), .timeout(timeout)
   );

   typedef struct {
      logic              port_b;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [1:0]        width;
      logic [31:0]       data;
   } txn_t;

   typedef struct {
      logic        port_b;
      logic [31:0] data;
   } rd_t;

   txn_t exp_q[$];
   rd_t  rd_q[$];
   txn_t t_mon;
   rd_t  r_mon;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   ack_cnt = 0;
   int   ack_base;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         if (a_ack || b_ack) ack_cnt++;
         if ((mem_rd && mem_rd_ready) || (mem_wr && mem_wr_ready)) begin
            if (exp_q.size() == 0) begin
               check("unexpected_handshake", 1, 0);
            end else begin
               t_mon = exp_q.pop_front();
               check("hs_port_b", {31'd0, b_ack}, {31'd0, t_mon.port_b});
               check("hs_one_ack", {31'd0, a_ack} + {31'd0, b_ack}, 1);
               check("hs_wr", {31'd0, mem_wr}, {31'd0, t_mon.wr});
               check("hs_rd", {31'd0, mem_rd}, {31'd0, ~t_mon.wr});
               check("hs_addr", 32'(mem_addr), 32'(t_mon.addr));
               check("hs_width", 32'(mem_data_width), 32'(t_mon.width));
               if (t_mon.wr) check("hs_wr_data", mem_wr_data, t_mon.data);
            end
         end else if (a_ack || b_ack) begin
            check("stray_ack", {31'd0, a_ack | b_ack}, 0);
         end
         if (a_rd_valid || b_rd_valid) begin
            if (rd_q.size() == 0) begin
               check("unexpected_rd_valid", 1, 0);
            end else begin
               r_mon = rd_q.pop_front();
               check("rdv_port_b", {31'd0, b_rd_valid}, {31'd0, r_mon.port_b});
               check("rdv_port_a", {31'd0, a_rd_valid}, {31'd0, ~r_mon.port_b});
               check("rdv_data", r_mon.port_b ? b_rd_data : a_rd_data, r_mon.data);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      exp_q.delete();
      rd_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic push_txn(input logic port_b, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [1:0] width, input logic [31:0] data);
      exp_q.push_back('{port_b: port_b, wr: wr, addr: addr, width: width, data: data});
   endtask

   task automatic wait_hs(input int budget);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if ((mem_rd && mem_rd_ready) || (mem_wr && mem_wr_ready)) seen = 1;
      end
      if (!seen) check("handshake_timeout", 0, 1);
   endtask

   // Call one #1 after a rising edge with the arbiter in WAIT_RD.
   task automatic rd_resp(input logic port_b, input logic [31:0] d);
      rd_q.push_back('{port_b: port_b, data: d});
      mem_rd_valid = 1'b1;
      mem_rd_data  = d;
      @(posedge clk);
      #1;
      mem_rd_valid = 1'b0;
      mem_rd_data  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout, 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_width", 32'(mem_data_width), 0);
      check("rst_wr_data", mem_wr_data, 0);
      check("rst_acks", {a_ack, b_ack}, 0);
      check("rst_rd_valids", {a_rd_valid, b_rd_valid}, 0);

      // 1: A write, then a back-to-back write two cycles later
      a_wr = 1; a_addr = 27'h10; a_width = DATA_WIDTH_32; a_wr_data = 32'h1122_3344;
      mem_wr_ready = 1;
      push_txn(0, 1, 27'h10, DATA_WIDTH_32, 32'h1122_3344);
      @(negedge clk);
      check("t1_no_strobe_yet", mem_wr, 0);
      @(negedge clk);
      check("t1_mem_wr", mem_wr, 1);
      check("t1_a_ack", a_ack, 1);
      check("t1_busy", busy, 1);
      @(posedge clk); #1;
      a_addr = 27'h14; a_wr_data = 32'h5566_7788;
      push_txn(0, 1, 27'h14, DATA_WIDTH_32, 32'h5566_7788);
      @(negedge clk);
      check("t1_gap_idle", mem_wr, 0);
      @(negedge clk);
      check("t1_b2b_mem_wr", mem_wr, 1);
      @(posedge clk); #1;
      a_wr = 0;
      @(negedge clk);
      check("t1_busy_done", busy, 0);

      // 2: B read, ready stalls 5 cycles, data returns later
      @(posedge clk); #1;
      b_rd = 1; b_addr = 27'h22; b_width = DATA_WIDTH_16;
      mem_rd_ready = 0; mem_wr_ready = 0;
      push_txn(1, 0, 27'h22, DATA_WIDTH_16, 0);
      @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         check("t2_rd_stalled", mem_rd, 1);
         check("t2_no_ack", b_ack, 0);
      end
      @(posedge clk); #1;
      mem_rd_ready = 1;
      @(negedge clk);
      check("t2_rd_6th", mem_rd, 1);
      check("t2_b_ack", b_ack, 1);
      @(posedge clk); #1;
      b_rd = 0; mem_rd_ready = 0;
      @(negedge clk);
      check("t2_rd_dropped", mem_rd, 0);
      check("t2_busy_wait", busy, 1);
      repeat (12) @(posedge clk);
      #1;
      check("t2_addr_held", 32'(mem_addr), 32'h22);
      check("t2_width_held", 32'(mem_data_width), 32'(DATA_WIDTH_16));
      rd_resp(1, 32'hABCD_0000);
      check("t2_b_rd_valid", b_rd_valid, 1);
      check("t2_b_rd_data", b_rd_data, 32'hABCD_0000);
      check("t2_a_rd_valid", a_rd_valid, 0);
      check("t2_idle", busy, 0);
      @(posedge clk); #1;
      check("t2_rd_valid_pulse", b_rd_valid, 0);

      // 3: both ports read continuously from reset; grants alternate A,B,A,B
      a_rd = 1; b_rd = 1; a_addr = 27'h100; b_addr = 27'h200;
      a_width = DATA_WIDTH_32; b_width = DATA_WIDTH_8;
      do_reset();
      mem_rd_ready = 1;
      for (int i = 0; i < 4; i++)
         push_txn(i[0], 0, i[0] ? 27'h200 : 27'h100, i[0] ? DATA_WIDTH_8 : DATA_WIDTH_32, 0);
      for (int i = 0; i < 4; i++) begin
         wait_hs(10);
         @(posedge clk); #1;
         if (i == 3) begin
            a_rd = 0; b_rd = 0;
         end
         rd_resp(i[0], 32'h1000_0000 + i);
      end
      @(negedge clk);

      // 4: read timeout
      @(posedge clk); #1;
      a_rd = 1; a_addr = 27'h30; a_width = DATA_WIDTH_32;
      push_txn(0, 0, 27'h30, DATA_WIDTH_32, 0);
      rd_q.push_back('{port_b: 1'b0, data: 32'hDEAD_BEEF});
      wait_hs(10);
      @(posedge clk); #1;
      a_rd = 0; mem_rd_ready = 0;
      repeat (16) @(negedge clk);
      check("t4_no_timeout_yet", timeout, 0);
      check("t4_busy_wait", busy, 1);
      @(negedge clk);
      check("t4_timeout", timeout, 1);
      check("t4_a_rd_valid", a_rd_valid, 1);
      check("t4_a_rd_data", a_rd_data, 32'hDEAD_BEEF);
      check("t4_idle", busy, 0);
      @(negedge clk);
      check("t4_timeout_pulse", timeout, 0);

      // 5: reset during WAIT_RD, then a late mem_rd_valid
      @(posedge clk); #1;
      b_rd = 1; b_addr = 27'h40; b_width = DATA_WIDTH_8; mem_rd_ready = 1;
      push_txn(1, 0, 27'h40, DATA_WIDTH_8, 0);
      wait_hs(10);
      @(posedge clk); #1;
      b_rd = 0; mem_rd_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      exp_q.delete();
      rd_q.delete();
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_addr", 32'(mem_addr), 0);
      check("t5_rst_width", 32'(mem_data_width), 0);
      check("t5_rst_a_rd_data", a_rd_data, 0);
      check("t5_rst_rd_valids", {a_rd_valid, b_rd_valid}, 0);
      @(posedge clk); #1;
      rst = 1;
      mem_rd_valid = 1; mem_rd_data = 32'h5555_5555;
      @(posedge clk); #1;
      mem_rd_valid = 0; mem_rd_data = '0;
      check("t5_late_valid_ignored", {a_rd_valid, b_rd_valid}, 0);
      check("t5_still_idle", busy, 0);
      a_rd = 1; b_rd = 1; a_addr = 27'h50; b_addr = 27'h60;
      a_width = DATA_WIDTH_16; b_width = DATA_WIDTH_16; mem_rd_ready = 1;
      push_txn(0, 0, 27'h50, DATA_WIDTH_16, 0);
      wait_hs(10);
      @(posedge clk); #1;
      a_rd = 0; b_rd = 0;
      rd_resp(0, 32'h7777_0001);
      @(negedge clk);

      // 6: rd and wr together resolve to a read with exactly one ack
      @(posedge clk); #1;
      a_rd = 1; a_wr = 1; a_addr = 27'h4; a_width = DATA_WIDTH_8; a_wr_data = 32'hFFFF_0000;
      mem_rd_ready = 1; mem_wr_ready = 1;
      ack_base = ack_cnt;
      push_txn(0, 0, 27'h4, DATA_WIDTH_8, 0);
      wait_hs(10);
      check("t6_mem_rd", mem_rd, 1);
      check("t6_mem_wr", mem_wr, 0);
      @(posedge clk); #1;
      a_rd = 0; a_wr = 0;
      rd_resp(0, 32'h0000_0042);
      repeat (3) @(negedge clk);
      check("t6_one_ack", ack_cnt - ack_base, 1);

      check("end_exp_q_empty", exp_q.size(), 0);
      check("end_rd_q_empty", rd_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
